// File: rtl/rr_select_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_select_mux: N-channel registered selector, round-robin/fixed/forced.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_select_mux #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int SELW     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic                      force_en,
   input  logic [SELW-1:0]           force_sel,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_sel,
   input  logic                      out_ready
);

   logic                r_valid;
   logic [WIDTH-1:0]    r_data;
   logic [SELW-1:0]     r_sel;
   logic [SELW-1:0]     r_ptr;

   logic                w_can_load;
   logic                w_found;
   logic [CHANNELS-1:0] w_grant;
   logic [SELW-1:0]     w_grant_idx;
   logic [WIDTH-1:0]    w_grant_data;
   logic                w_accept;
   logic                w_rr_accept;
   logic [SELW-1:0]     w_ptr_next;

   assign w_can_load = ~r_valid | out_ready;

   // Round-robin runs as two passes: channels at or above ptr first, then the wrap.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      if (force_en) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (force_sel == SELW'(i)) begin
               w_grant[i] = in_valid[i];
            end
         end
      end else if (mode) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && in_valid[i]) begin
               w_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && in_valid[i] && (SELW'(i) >= r_ptr)) begin
               w_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
         for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && in_valid[i]) begin
               w_grant[i] = 1'b1;
               w_found    = 1'b1;
            end
         end
      end
   end

   // Grant is one-hot or zero, so OR-reduction acts as encoder and mux.
   always_comb begin
      w_grant_idx  = '0;
      w_grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_grant[i]) begin
            w_grant_idx  = w_grant_idx | SELW'(i);
            w_grant_data = w_grant_data | in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign in_ready    = w_grant & {CHANNELS{w_can_load & ~rst}};
   assign w_accept    = |in_ready;
   assign w_rr_accept = w_accept & ~force_en & ~mode;
   assign w_ptr_next  = (w_grant_idx == SELW'(CHANNELS - 1)) ? '0 : w_grant_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_grant_data;
            r_sel   <= w_grant_idx;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
         if (w_rr_accept) begin
            r_ptr <= w_ptr_next;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_select_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_select_mux: directed + random checks against a reference model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rr_select_mux;
   localparam int W = 32;
   localparam int C = 4;
   localparam int S = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [C-1:0]   in_valid;
   logic [C*W-1:0] in_data;
   logic [C-1:0]   in_ready;
   logic           mode;
   logic           force_en;
   logic [S-1:0]   force_sel;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [S-1:0]   out_sel;
   logic           out_ready;

   // Five-channel instance so that out-of-range force_sel values are representable.
   logic           rst5;
   logic [4:0]     in_valid5;
   logic [39:0]    in_data5;
   logic [4:0]     in_ready5;
   logic           mode5;
   logic           force_en5;
   logic [2:0]     force_sel5;
   logic           out_valid5;
   logic [7:0]     out_data5;
   logic [2:0]     out_sel5;
   logic           out_ready5;

   int n_assert = 0;
   int n_fail   = 0;

   bit         m_valid;
   logic [W-1:0] m_data;
   int         m_sel;
   int         m_ptr;

   always #5 clk = ~clk;

   rr_select_mux #(.WIDTH(W), .CHANNELS(C), .SELW(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mode(mode), .force_en(force_en), .force_sel(force_sel), .out_valid(out_valid),
      .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
   );

   rr_select_mux #(.WIDTH(8), .CHANNELS(5), .SELW(3)) dut5 (
      .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
      .mode(mode5), .force_en(force_en5), .force_sel(force_sel5), .out_valid(out_valid5),
      .out_data(out_data5), .out_sel(out_sel5), .out_ready(out_ready5)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      int fs;
      fs = int'(force_sel);
      if (force_en) return (fs < C && in_valid[fs]) ? fs : -1;
      if (mode) begin
         for (int i = 0; i < C; i++) if (in_valid[i]) return i;
         return -1;
      end
      for (int o = 0; o < C; o++) if (in_valid[(m_ptr + o) % C]) return (m_ptr + o) % C;
      return -1;
   endfunction

   function automatic logic [W-1:0] word(input int ch);
      return in_data[ch*W +: W];
   endfunction

   // One clock: check the combinational accept, advance, update model, check outputs.
   task automatic cycle();
      int           g;
      bit           load;
      bit           rr;
      logic [C-1:0] er;
      logic [W-1:0] d;
      #1;
      g    = pick();
      load = !rst && g >= 0 && (!m_valid || out_ready);
      rr   = !force_en && !mode;
      er   = '0;
      d    = '0;
      if (load) begin
         er[g] = 1'b1;
         d     = word(g);
      end
      chk("in_ready", in_ready, er);
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
      end else if (load) begin
         m_valid = 1; m_data = d; m_sel = g;
         if (rr) m_ptr = (g + 1) % C;
      end else if (out_ready) begin
         m_valid = 0;
      end
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_sel", out_sel, m_sel);
      @(negedge clk);
   endtask

   initial begin
      rst = 1; mode = 0; force_en = 0; force_sel = '0; out_ready = 1; in_valid = '1;
      for (int i = 0; i < C; i++) in_data[i*W +: W] = 32'hA0 + i;
      rst5 = 1; mode5 = 0; force_en5 = 0; force_sel5 = '0; out_ready5 = 1;
      in_valid5 = '0; in_data5 = 40'h44_33_22_11_00;
      m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
      @(negedge clk);

      // Reset held two cycles with all channels requesting
      repeat (2) begin
         cycle();
         chk("rst_ready", in_ready, 4'b0000);
         chk("rst_valid", out_valid, 1'b0);
      end

      // Round-robin rotation
      rst = 0;
      for (int c = 0; c < 8; c++) begin
         cycle();
         chk("rr_sel", out_sel, c % 4);
         chk("rr_data", out_data, 32'hA0 + (c % 4));
      end

      // Fixed priority, then round-robin skip from ptr=2
      mode = 1; in_valid = 4'b1010;
      repeat (3) begin
         cycle();
         chk("fp_sel", out_sel, 1);
      end
      mode = 0; in_valid = 4'b0010; cycle();
      chk("fp_ptr_kept", out_sel, 0 + 1);
      in_valid = 4'b0011; cycle();
      chk("skip_sel", out_sel, 0);
      in_valid = 4'b1111; cycle();
      chk("skip_ptr1", out_sel, 1);

      // Back-pressure
      in_valid = 4'b0100; in_data[2*W +: W] = 32'h1234; cycle();
      chk("bp_load", out_data, 32'h1234);
      out_ready = 0; in_valid = 4'b1111;
      repeat (3) begin
         cycle();
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_data", out_data, 32'h1234);
         chk("bp_hold_ready", in_ready, 4'b0000);
      end
      out_ready = 1; cycle();
      chk("bp_nobubble_valid", out_valid, 1'b1);
      chk("bp_nobubble_sel", out_sel, 3);

      // Forced select
      force_en = 1; force_sel = 2'd3; in_valid = 4'b0111; cycle();
      chk("force_drain", out_valid, 1'b0);
      in_valid = 4'b1111;
      repeat (2) begin
         cycle();
         chk("force_sel3", out_sel, 3);
      end
      force_en = 0;

      // Reset mid-operation discards the held word and the pointer
      in_valid = 4'b0001; cycle();
      out_ready = 0; in_valid = 4'b0000; cycle();
      chk("mid_held", out_valid, 1'b1);
      rst = 1; cycle();
      chk("mid_rst_valid", out_valid, 1'b0);
      rst = 0; out_ready = 1;
      repeat (2) begin
         cycle();
         chk("mid_no_replay", out_valid, 1'b0);
      end
      in_valid = 4'b1111; cycle();
      chk("mid_ptr0", out_sel, 0);

      // Out-of-range forced index on the five-channel instance
      rst5 = 0; force_en5 = 1; in_valid5 = 5'h1F;
      for (int fs = 5; fs < 8; fs++) begin
         force_sel5 = 3'(fs);
         #1;
         chk("force_oob_ready", in_ready5, 5'b00000);
         @(posedge clk); #1;
         chk("force_oob_valid", out_valid5, 1'b0);
         @(negedge clk);
      end
      force_sel5 = 3'd4;
      #1;
      chk("force4_ready", in_ready5, 5'b10000);
      @(posedge clk); #1;
      chk("force4_sel", out_sel5, 3'd4);
      chk("force4_data", out_data5, 8'h44);
      @(negedge clk);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 31) == 0);
         mode      = $urandom_range(0, 3) == 0;
         force_en  = $urandom_range(0, 4) == 0;
         force_sel = S'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         in_valid  = C'($urandom);
         for (int i = 0; i < C; i++) in_data[i*W +: W] = $urandom;
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
